// File: rtl/maq_pkg.sv
// Shared definitions for the drink dispenser: state codes, coin-type codes
// and coin values in 25-cent units.
package maq_pkg;

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    VALIDA = 3'd1,
    REFRI  = 3'd2,
    MOEDA  = 3'd3,
    PAUSA  = 3'd4,
    ERRO   = 3'd5
  } estado_t;

  localparam logic [1:0] TIPO_NENHUMA = 2'b00;
  localparam logic [1:0] TIPO_25      = 2'b01;
  localparam logic [1:0] TIPO_50      = 2'b10;

  localparam logic [3:0] VALOR_25 = 4'd1;
  localparam logic [3:0] VALOR_50 = 4'd2;

  // Largest coin that still fits in the remaining change.
  function automatic logic [1:0] tipo_moeda(input logic [3:0] troco);
    return (troco >= VALOR_50) ? TIPO_50 : TIPO_25;
  endfunction

endpackage

// File: rtl/maq_timeout.sv
// Actuator acknowledge watchdog: counts cycles spent waiting for an ack and
// flags the cycle in which the wait would reach TIMEOUT.
module maq_timeout #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Only a missed-ack cycle can expire, so an ack on the final cycle wins.
  assign expired = count_en && (count == LAST);

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/maq_dispensa.sv
// Vending machine controller: validates credit, dispenses a drink and returns
// change coin by coin, with an ack watchdog that locks into an error state.
module maq_dispensa
  import maq_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pedido,
  input  logic [3:0] credito,
  input  logic [3:0] preco,
  input  logic       refri_ack,
  input  logic       moeda_ack,
  output logic       pronto,
  output logic       refri_req,
  output logic       moeda_req,
  output logic [1:0] moeda_tipo,
  output logic       erro,
  output logic [2:0] saida_estado
);

  estado_t    state, state_nxt;
  logic [3:0] troco, troco_nxt;
  logic [3:0] credito_q, preco_q;
  logic       load;
  logic       clear, count_en, expired;

  // Change left after ejecting one coin; never wraps below zero.
  function automatic logic [3:0] troco_apos(input logic [3:0] t);
    if (t >= VALOR_50)      return t - VALOR_50;
    else if (t >= VALOR_25) return t - VALOR_25;
    else                    return '0;
  endfunction

  assign count_en = ((state == REFRI) && !refri_ack) ||
                    ((state == MOEDA) && !moeda_ack);
  assign clear    = ((state_nxt == REFRI) || (state_nxt == MOEDA)) &&
                    (state_nxt != state);

  maq_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .count_en (count_en),
    .expired  (expired)
  );

  always_comb begin
    state_nxt = state;
    troco_nxt = troco;
    load      = 1'b0;
    case (state)
      OCIOSO: begin
        if (pedido) begin
          load      = 1'b1;
          state_nxt = VALIDA;
        end
      end
      VALIDA: begin
        if (credito_q >= preco_q) begin
          troco_nxt = credito_q - preco_q;
          state_nxt = REFRI;
        end else begin
          troco_nxt = credito_q;
          state_nxt = (credito_q == '0) ? OCIOSO : MOEDA;
        end
      end
      REFRI: begin
        if (refri_ack)    state_nxt = (troco != '0) ? MOEDA : OCIOSO;
        else if (expired) state_nxt = ERRO;
      end
      MOEDA: begin
        if (moeda_ack) begin
          troco_nxt = troco_apos(troco);
          state_nxt = PAUSA;
        end else if (expired) begin
          state_nxt = ERRO;
        end
      end
      PAUSA:   state_nxt = (troco != '0) ? MOEDA : OCIOSO;
      ERRO:    state_nxt = ERRO;
      default: begin
        state_nxt = OCIOSO;
        troco_nxt = '0;
      end
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state <= OCIOSO;
      troco <= '0;
    end else begin
      state <= state_nxt;
      troco <= troco_nxt;
    end
  end

  // Purchase operands are data only; they are always written before use.
  always_ff @(negedge clk) begin
    if (load) begin
      credito_q <= credito;
      preco_q   <= preco;
    end
  end

  assign pronto       = (state == OCIOSO);
  assign refri_req    = (state == REFRI);
  assign moeda_req    = (state == MOEDA);
  assign moeda_tipo   = (state == MOEDA) ? tipo_moeda(troco) : TIPO_NENHUMA;
  assign erro         = (state == ERRO);
  assign saida_estado = state;

endmodule

// File: doc/maq_dispensa.md
MAQ_DISPENSA -- requirements
Module: maq_dispensa

Interface
REQ-001 The block SHALL have the parameter TIMEOUT, default 15, meaning the maximum cycles to wait for an actuator acknowledge.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes occur on its falling edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the port pedido, input, 1 bit: purchase request, sampled only while pronto=1.
REQ-005 The block SHALL have the port credito, input, 4 bits: inserted credit in 25-cent units (0-15).
REQ-006 The block SHALL have the port preco, input, 4 bits: product price in 25-cent units.
REQ-007 The block SHALL have the port refri_ack, input, 1 bit: drink actuator done.
REQ-008 The block SHALL have the port moeda_ack, input, 1 bit: coin actuator done.
REQ-009 The block SHALL have the port pronto, output, 1 bit: idle, ready for a request.
REQ-010 The block SHALL have the port refri_req, output, 1 bit: drink dispense request, level.
REQ-011 The block SHALL have the port moeda_req, output, 1 bit: coin eject request, level.
REQ-012 The block SHALL have the port moeda_tipo, output, 2 bits: coin type; 2'b10 = 50c, 2'b01 = 25c, 2'b00 = none.
REQ-013 The block SHALL have the port erro, output, 1 bit: actuator timeout, sticky.
REQ-014 The block SHALL have the port saida_estado, output, 3 bits: current state code, for debug.

Function
REQ-015 The block SHALL be a Moore machine: every output decodes only from the state register and the registered troco.
REQ-016 The states SHALL be OCIOSO=0, VALIDA=1, REFRI=2, MOEDA=3, PAUSA=4, ERRO=5; codes 6-7 SHALL return to OCIOSO on the next edge.
REQ-017 In OCIOSO, pronto=1; pedido=1 SHALL latch credito and preco and move to VALIDA; pedido in any other state SHALL be ignored.
REQ-018 In VALIDA, if credito>=preco then troco<=credito-preco and the next state is REFRI; otherwise troco<=credito (full refund) and the next state is MOEDA, or OCIOSO if credito=0.
REQ-019 In REFRI, refri_req=1 is held until refri_ack=1 is sampled; the next state is then MOEDA if troco!=0, else OCIOSO.
REQ-020 In MOEDA, moeda_req=1 and moeda_tipo=2'b10 if troco>=2, else 2'b01; on moeda_ack=1, troco decrements by the coin value and the next state is PAUSA.
REQ-021 PAUSA SHALL last exactly one cycle with moeda_req=0, then go to MOEDA if troco!=0, else OCIOSO.
REQ-022 Arithmetic SHALL be 4-bit unsigned; troco SHALL never underflow (25c is chosen when troco=1).
REQ-023 A timeout counter SHALL clear on entry to REFRI or MOEDA and increment each cycle without the relevant ack; reaching TIMEOUT SHALL move the block to ERRO.
REQ-024 An ack arriving in the same cycle the counter reaches TIMEOUT SHALL win: normal progress, no error.
REQ-025 ERRO SHALL assert erro=1 with all requests low, and SHALL be left only by reset.
REQ-026 Acks sampled outside REFRI/MOEDA SHALL be ignored; refri_ack does not advance MOEDA and vice versa.
REQ-027 Latency from pedido to refri_req SHALL be 2 edges (OCIOSO->VALIDA->REFRI).

Reset
REQ-028 rst=0 SHALL immediately force OCIOSO, troco=0, counter=0, pronto=1, refri_req=0, moeda_req=0, moeda_tipo=0, erro=0, saida_estado=0, including mid-dispense.
REQ-029 The first request after release SHALL be accepted on the first falling edge with rst=1.

Structure
REQ-030 State codes, coin-type codes and the coin unit values (1 and 2) SHALL live in the shared package maq_pkg.
REQ-031 The timeout counter SHALL be the sub-module maq_timeout (inputs: clear, count_en; output: expired).

Verification
REQ-032 credito=6, preco=3, pedido pulse, acks returned after 2 cycles -> refri_req, then moeda_tipo 10 then 01, then pronto=1; total change 3.
REQ-033 credito=2, preco=5 -> no refri_req; a single 50c coin; then OCIOSO.
REQ-034 credito=4, preco=4 -> refri_req only, no moeda_req, then pronto=1.
REQ-035 refri_ack withheld -> erro=1 after TIMEOUT cycles; persists; rst=0 clears it.
REQ-036 rst=0 asserted while moeda_req=1 -> all outputs at reset values asynchronously; a fresh request then works.
REQ-037 moeda_ack held high continuously -> one decrement per MOEDA visit; PAUSA drops moeda_req for exactly one cycle.
